// File: rtl/gesture_pkg.sv
// Shared types and helpers for the gesture event decoder.
// Optional repeat filter is enabled by GESTURE_REPEAT_FILTER_EN.
package gesture_pkg;

  localparam int GMAX = 32;
  localparam int GIDX_W = 5;
  localparam int NUM_GEST_DEF = 8;

  function automatic int gest_code_w(input int n);
    return $clog2(n);
  endfunction

  localparam int GEST_CODE_W = gest_code_w(NUM_GEST_DEF);

  typedef logic [GEST_CODE_W-1:0] gest_code_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } hold_state_t;

  // lowest set bit wins
  function automatic logic [GIDX_W-1:0] prio_enc(
    input logic [GMAX-1:0] v
  );
    logic [GIDX_W-1:0] idx;
    idx = '0;
    for (int i = GMAX - 1; i >= 0; i--)
      if (v[i]) idx = GIDX_W'(i);
    return idx;
  endfunction

  function automatic logic [GMAX-1:0] onehot(
    input logic [GIDX_W-1:0] idx
  );
    logic [GMAX-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/gesture_evt_fifo.sv
// Small synchronous FIFO holding encoded gesture codes.
// Head is registered storage; a push while empty shows up next cycle.
module gesture_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign o_level = r_level;
  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_data  = r_mem[r_rd];
  assign w_pop   = i_pop & ~o_empty;
  // a full FIFO may still take a push when the head leaves
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/gesture_event_decoder.sv
// Edge-detects and arbitrates raw gesture bits into pulse, hold and queued events.
// Define GESTURE_REPEAT_FILTER_EN to suppress same-index repeats within REPEAT_CYC.
module gesture_event_decoder
  import gesture_pkg::*;
#(
  parameter int NUM_GEST   = 8,
  parameter int DEPTH      = 4,
  parameter int HOLD_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 50_000_000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_GEST-1:0]         gest_data,
  output logic [NUM_GEST-1:0]         gest_pulse,
  output logic [NUM_GEST-1:0]         gest_hold,
  output logic                        evt_valid,
  output logic [$clog2(NUM_GEST)-1:0] evt_code,
  input  logic                        evt_ready,
  output logic [$clog2(DEPTH):0]      evt_level,
  output logic                        evt_overflow,
  input  logic                        ovf_clr
);

  localparam int CW = gest_code_w(NUM_GEST);
  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  if (NUM_GEST < 2 || NUM_GEST > GMAX || DEPTH < 2 ||
      HOLD_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_param
    $error("gesture_event_decoder: bad parameter");
  end

  logic [NUM_GEST-1:0] r_data_d;
  logic [NUM_GEST-1:0] w_rise;
  logic [NUM_GEST-1:0] w_oh;
  logic [CW-1:0]       w_idx;
  logic                w_any;
  logic                w_accept;
  logic                w_pop;
  logic                w_push;
  logic                w_full;
  logic                w_empty;
  logic                w_ovf_set;

  assign w_rise = gest_data & ~r_data_d;
  assign w_any  = |w_rise;
  assign w_idx  = CW'(prio_enc(GMAX'(w_rise)));
  assign w_oh   = NUM_GEST'(onehot(GIDX_W'(w_idx)));

`ifdef GESTURE_REPEAT_FILTER_EN
  localparam int RW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;

  logic [CW-1:0] r_last_idx;
  logic [RW-1:0] r_win_cnt;
  logic          r_win_act;

  assign w_accept = w_any & ~(r_win_act & (r_last_idx == w_idx));

  // suppressed repeats leave the window running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_idx <= '0;
      r_win_cnt  <= '0;
      r_win_act  <= 1'b0;
    end else if (w_accept) begin
      r_last_idx <= w_idx;
      r_win_cnt  <= RW'(REPEAT_CYC - 1);
      r_win_act  <= 1'b1;
    end else if (r_win_act) begin
      if (r_win_cnt == '0)
        r_win_act <= 1'b0;
      else
        r_win_cnt <= r_win_cnt - RW'(1);
    end
  end
`else
  assign w_accept = w_any;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_d   <= '0;
      gest_pulse <= '0;
    end else begin
      r_data_d   <= gest_data;
      gest_pulse <= w_accept ? w_oh : '0;
    end
  end

  hold_state_t         r_state;
  hold_state_t         w_state_nxt;
  logic [HW-1:0]       r_cnt;
  logic [HW-1:0]       w_cnt_nxt;
  logic [NUM_GEST-1:0] r_hold;
  logic [NUM_GEST-1:0] w_hold_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hold_nxt  = r_hold;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = HW'(HOLD_CYC - 1);
          w_hold_nxt  = w_oh;
        end
      end
      HOLD: begin
        if (w_accept) begin
          w_cnt_nxt  = HW'(HOLD_CYC - 1);
          w_hold_nxt = w_oh;
        end else if (r_cnt == '0) begin
          w_state_nxt = IDLE;
          w_hold_nxt  = '0;
        end else begin
          w_cnt_nxt = r_cnt - HW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_hold_nxt  = '0;
      end
    endcase
  end

  assign gest_hold = r_hold;

  gesture_evt_fifo #(
    .DEPTH (DEPTH),
    .W     (CW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_idx),
    .i_pop   (w_pop),
    .o_data  (evt_code),
    .o_level (evt_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign evt_valid = ~w_empty;
  assign w_pop     = evt_valid & evt_ready;
  assign w_push    = w_accept & (~w_full | w_pop);
  assign w_ovf_set = w_accept & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      evt_overflow <= 1'b0;
    else if (w_ovf_set)
      evt_overflow <= 1'b1;
    else if (ovf_clr)
      evt_overflow <= 1'b0;
  end

endmodule

// File: tb/tb_gesture_event_decoder.sv
// Bench for gesture_event_decoder: vector table, corner sequences, random vs model.
// Repeat-filter expectations follow GESTURE_REPEAT_FILTER_EN.
module tb_gesture_event_decoder;

  localparam int NG = 8;
  localparam int DP = 4;
  localparam int HC = 8;
  localparam int RC = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] gd = '0;
  logic       rdy = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] gp;
  logic [7:0] gh;
  logic       valid;
  logic [2:0] code;
  logic [2:0] level;
  logic       ovf;

  always #5 clk = ~clk;

  gesture_event_decoder #(
    .NUM_GEST   (NG),
    .DEPTH      (DP),
    .HOLD_CYC   (HC),
    .REPEAT_CYC (RC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gest_data    (gd),
    .gest_pulse   (gp),
    .gest_hold    (gh),
    .evt_valid    (valid),
    .evt_code     (code),
    .evt_ready    (rdy),
    .evt_level    (level),
    .evt_overflow (ovf),
    .ovf_clr      (clr)
  );

  int checks = 0;
  int errors = 0;

  // reference model: timestamps and a queue
  logic [7:0] m_prev;
  int         q[$];
  bit         m_ovf;
  int         m_cyc;
  bit         m_pv;
  int         m_pidx;
  bit         m_hv;
  int         m_hidx;
  int         m_hend;
  bit         m_lv;
  int         m_lidx;
  int         m_lcyc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_prev = '0;
    q.delete();
    m_ovf = 0;
    m_pv = 0;
    m_hv = 0;
    m_lv = 0;
  endtask

  task automatic model_edge();
    logic [7:0] rise;
    int idx;
    bit acc;
    bit pop;
    bit ovfset;
    m_cyc++;
    rise = gd & ~m_prev;
    m_prev = gd;
    pop = (q.size() > 0) && rdy;
    acc = 0;
    idx = 0;
    for (int i = NG - 1; i >= 0; i--)
      if (rise[i]) begin
        idx = i;
        acc = 1;
      end
`ifdef GESTURE_REPEAT_FILTER_EN
    if (acc && m_lv && idx == m_lidx && (m_cyc - m_lcyc) <= RC)
      acc = 0;
`endif
    m_pv = acc;
    m_pidx = idx;
    ovfset = acc && q.size() == DP && !pop;
    if (pop) void'(q.pop_front());
    if (acc && !ovfset) q.push_back(idx);
    if (ovfset) m_ovf = 1;
    else if (clr) m_ovf = 0;
    if (acc) begin
      m_hv = 1;
      m_hidx = idx;
      m_hend = m_cyc + HC;
      m_lv = 1;
      m_lidx = idx;
      m_lcyc = m_cyc;
    end
  endtask

  task automatic model_cmp();
    int ep;
    int eh;
    ep = m_pv ? (1 << m_pidx) : 0;
    eh = (m_hv && m_cyc < m_hend) ? (1 << m_hidx) : 0;
    chk("pulse", 32'(gp), 32'(ep));
    chk("hold", 32'(gh), 32'(eh));
    chk("valid", 32'(valid), 32'(q.size() > 0));
    chk("level", 32'(level), 32'(q.size()));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    if (q.size() > 0) chk("code", 32'(code), 32'(q[0]));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    model_cmp();
  endtask

  task automatic tap(input logic [7:0] pat);
    gd = pat;
    step();
    gd = '0;
    step();
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_pulse"}, 32'(gp), 32'(0));
    chk({nm, "_hold"}, 32'(gh), 32'(0));
    chk({nm, "_valid"}, 32'(valid), 32'(0));
    chk({nm, "_level"}, 32'(level), 32'(0));
    chk({nm, "_ovf"}, 32'(ovf), 32'(0));
    chk({nm, "_code"}, 32'(code), 32'(0));
  endtask

  typedef struct {
    logic [7:0] gd;
    logic       rdy;
    logic       clr;
    logic [7:0] p;
    logic [7:0] h;
    logic       v;
    logic [2:0] c;
    logic [2:0] l;
    logic       o;
  } vec_t;

  vec_t tbl[13];
  int   exp_codes[4];
  logic [7:0] pulse2;

  initial begin
    tbl[0]  = '{8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0};
    tbl[1]  = '{8'h04, 1'b0, 1'b0, 8'h04, 8'h04, 1'b1, 3'd2, 3'd1, 1'b0};
    tbl[2]  = '{8'h04, 1'b1, 1'b0, 8'h00, 8'h04, 1'b0, 3'd0, 3'd0, 1'b0};
    tbl[3]  = '{8'h00, 1'b1, 1'b0, 8'h00, 8'h04, 1'b0, 3'd0, 3'd0, 1'b0};
    tbl[4]  = '{8'h00, 1'b1, 1'b1, 8'h00, 8'h04, 1'b0, 3'd0, 3'd0, 1'b0};
    tbl[5]  = '{8'h00, 1'b1, 1'b0, 8'h00, 8'h04, 1'b0, 3'd0, 3'd0, 1'b0};
    tbl[6]  = '{8'h00, 1'b1, 1'b0, 8'h00, 8'h04, 1'b0, 3'd0, 3'd0, 1'b0};
    tbl[7]  = '{8'h00, 1'b1, 1'b0, 8'h00, 8'h04, 1'b0, 3'd0, 3'd0, 1'b0};
    tbl[8]  = '{8'h00, 1'b1, 1'b0, 8'h00, 8'h04, 1'b0, 3'd0, 3'd0, 1'b0};
    tbl[9]  = '{8'h00, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0, 1'b0};
    tbl[10] = '{8'h28, 1'b0, 1'b0, 8'h08, 8'h08, 1'b1, 3'd3, 3'd1, 1'b0};
    tbl[11] = '{8'h28, 1'b0, 1'b0, 8'h00, 8'h08, 1'b1, 3'd3, 3'd1, 1'b0};
    tbl[12] = '{8'h28, 1'b1, 1'b0, 8'h00, 8'h08, 1'b0, 3'd0, 3'd0, 1'b0};

    m_cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    #2 rst_n = 1'b1;

    // basic edge, pop, hold length and multi-bit arbitration
    for (int i = 0; i < 13; i++) begin
      gd = tbl[i].gd;
      rdy = tbl[i].rdy;
      clr = tbl[i].clr;
      step();
      chk("tbl_pulse", 32'(gp), 32'(tbl[i].p));
      chk("tbl_hold", 32'(gh), 32'(tbl[i].h));
      chk("tbl_valid", 32'(valid), 32'(tbl[i].v));
      chk("tbl_level", 32'(level), 32'(tbl[i].l));
      chk("tbl_ovf", 32'(ovf), 32'(tbl[i].o));
      if (tbl[i].v) chk("tbl_code", 32'(code), 32'(tbl[i].c));
    end

    // overflow with a stalled consumer
    gd = '0;
    rdy = 1'b0;
    clr = 1'b0;
    step();
    tap(8'h01);
    tap(8'h02);
    tap(8'h04);
    tap(8'h08);
    tap(8'h10);
    chk("ovf_level", 32'(level), 32'(4));
    chk("ovf_flag", 32'(ovf), 32'(1));
    for (int k = 0; k < 4; k++) begin
      chk("ovf_order", 32'(code), 32'(k));
      rdy = 1'b1;
      step();
    end
    chk("ovf_drained", 32'(level), 32'(0));
    chk("ovf_sticky", 32'(ovf), 32'(1));
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'(0));

    // hold retrigger to a different gesture
    gd = 8'h02;
    step();
    chk("retrig_first", 32'(gh), 32'(8'h02));
    gd = '0;
    repeat (4) step();
    chk("retrig_old", 32'(gh), 32'(8'h02));
    gd = 8'h40;
    step();
    chk("retrig_new", 32'(gh), 32'(8'h40));
    gd = '0;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("retrig_keep", 32'(gh), 32'(8'h40));
    end
    step();
    chk("retrig_end", 32'(gh), 32'(0));

    // full FIFO with simultaneous push and pop
    rdy = 1'b0;
    tap(8'h01);
    tap(8'h02);
    tap(8'h04);
    tap(8'h08);
    chk("full_level", 32'(level), 32'(4));
    gd = 8'h20;
    rdy = 1'b1;
    step();
    gd = '0;
    chk("pp_level", 32'(level), 32'(4));
    chk("pp_ovf", 32'(ovf), 32'(0));
    chk("pp_pulse", 32'(gp), 32'(8'h20));
    exp_codes = '{1, 2, 3, 5};
    for (int k = 0; k < 4; k++) begin
      chk("pp_order", 32'(code), 32'(exp_codes[k]));
      step();
    end
    chk("pp_drained", 32'(level), 32'(0));

    // same gesture repeated 10 and 20 cycles apart
    gd = 8'h01;
    step();
    chk("rep_first", 32'(gp), 32'(8'h01));
    gd = '0;
    repeat (9) step();
    gd = 8'h01;
    step();
`ifdef GESTURE_REPEAT_FILTER_EN
    pulse2 = 8'h00;
`else
    pulse2 = 8'h01;
`endif
    chk("rep_second", 32'(gp), 32'(pulse2));
    gd = '0;
    repeat (9) step();
    gd = 8'h01;
    step();
    chk("rep_third", 32'(gp), 32'(8'h01));
    gd = '0;
    step();

    // asynchronous reset mid-hold with a queued event
    rdy = 1'b0;
    gd = 8'h08;
    step();
    gd = '0;
    step();
    step();
    chk("pre_rst_hold", 32'(gh), 32'(8'h08));
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    #2 rst_n = 1'b1;
    rdy = 1'b1;
    step();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      gd = 8'($urandom) & 8'($urandom) & 8'($urandom);
      if (n < 300) rdy = ($urandom_range(0, 3) == 0);
      else rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
